// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: issues one op, waits the ALU latency, queues results.
// Optional saturating perf counters are built when ALU_SEQ_PERF_EN is defined.
module alu_cmd_sequencer #(
  parameter int DW        = 8,
  parameter int CW        = 4,
  parameter int LAT       = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic [DW-1:0]   REQ_OPA,
  input  logic [DW-1:0]   REQ_OPB,
  input  logic            REQ_CIN,
  input  logic            REQ_MODE,
  input  logic [CW-1:0]   REQ_CMD,
  input  logic            REQ_SPLIT,
  output logic [1:0]      INP_VALID,
  output logic [DW-1:0]   OPA,
  output logic [DW-1:0]   OPB,
  output logic            CIN,
  output logic [CW-1:0]   CMD,
  output logic            MODE,
  output logic            CE,
  input  logic [2*DW-1:0] RES,
  input  logic            COUT,
  input  logic            OFLOW,
  input  logic            G,
  input  logic            E,
  input  logic            L,
  input  logic            ERR,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic [2*DW-1:0] RSP_RES,
  output logic [5:0]      RSP_FLAGS,
  output logic [15:0]     PERF_ISSUED,
  output logic [15:0]     PERF_ERR
);

  localparam int AW = $clog2(RSP_DEPTH);
  localparam int FW = 2*DW + 6;
  localparam int TW = $clog2(LAT + 2);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RSP_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_A,
    ISSUE_B,
    WAIT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   h_opb;
  logic            h_split;
  logic [TW-1:0]   cnt;
  logic [TW-1:0]   leff_m1;
  logic            is_mul;
  logic            accept;
  logic            push;
  logic            pop;
  logic            full;
  logic [FW-1:0]   mem [RSP_DEPTH];
  logic [FW-1:0]   rsp_word;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  assign full      = (count == FULL_CNT);
  assign REQ_READY = RST && (state == IDLE) && !full;
  assign accept    = REQ_VALID && REQ_READY;
  assign push      = (state == WAIT) && (cnt == '0);
  assign RSP_VALID = (count != '0);
  assign pop       = RSP_VALID && RSP_READY;

  // Multiplies take one extra ALU cycle.
  assign is_mul  = MODE && ((CMD == CW'(9)) || (CMD == CW'(10)));
  assign leff_m1 = is_mul ? TW'(LAT) : TW'(LAT - 1);

  always_comb begin
    state_nxt = state;
    INP_VALID = 2'b00;
    CE        = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = ISSUE_A;
      end
      ISSUE_A: begin
        CE        = 1'b1;
        INP_VALID = h_split ? 2'b01 : 2'b11;
        state_nxt = h_split ? ISSUE_B : WAIT;
      end
      ISSUE_B: begin
        CE        = 1'b1;
        INP_VALID = 2'b10;
        state_nxt = WAIT;
      end
      WAIT: begin
        CE = 1'b1;
        if (cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      OPA     <= '0;
      OPB     <= '0;
      CIN     <= 1'b0;
      CMD     <= '0;
      MODE    <= 1'b0;
      h_opb   <= '0;
      h_split <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        OPA     <= REQ_OPA;
        h_opb   <= REQ_OPB;
        CIN     <= REQ_CIN;
        CMD     <= REQ_CMD;
        MODE    <= REQ_MODE;
        h_split <= REQ_SPLIT;
        if (!REQ_SPLIT) OPB <= REQ_OPB;
      end
      // Split ops present OPB only in the second issue cycle.
      if (state == ISSUE_A && h_split) OPB <= h_opb;
      if (state != WAIT && state_nxt == WAIT) begin
        cnt <= leff_m1;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {ERR, COUT, OFLOW, G, E, L, RES};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rsp_word  = mem[rd_ptr];
  assign RSP_RES   = rsp_word[2*DW-1:0];
  assign RSP_FLAGS = rsp_word[FW-1:2*DW];

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PERF_ISSUED <= '0;
      PERF_ERR    <= '0;
    end else begin
      if (accept && PERF_ISSUED != 16'hFFFF)
        PERF_ISSUED <= PERF_ISSUED + 16'd1;
      if (push && ERR && PERF_ERR != 16'hFFFF)
        PERF_ERR <= PERF_ERR + 16'd1;
    end
  end
`else
  assign PERF_ISSUED = '0;
  assign PERF_ERR    = '0;
`endif

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Synthesizable command sequencer for the `ALU_DESIGN` operand/command port. It accepts whole ALU operations on a valid/ready request channel and drives `INP_VALID`, `OPA`, `OPB`, `CIN`, `CMD`, `MODE` and `CE`. It waits the ALU result latency, captures `RES` and the flags, and returns them on a valid/ready response channel through a small FIFO. It sits between a host/CPU-side command source and the ALU, and is the RTL-side replacement for the testbench driver.

## Interface
Parameters:
- `DW`, default 8: operand width.
- `CW`, default 4: command width.
- `LAT`, default 1: ALU result latency in cycles, for non-multiply commands.
- `RSP_DEPTH`, default 4: response FIFO depth; must be a power of 2, at least 2.

Ports:
- `CLK` in, 1: clock, rising edge.
- `RST` in, 1: asynchronous, active-low reset.
- `REQ_VALID` in, 1 / `REQ_READY` out, 1: request handshake.
- `REQ_OPA`, `REQ_OPB` in, DW: operands.
- `REQ_CIN` in, 1 / `REQ_MODE` in, 1 / `REQ_CMD` in, CW: operation.
- `REQ_SPLIT` in, 1: send OPA and OPB in separate cycles.
- `INP_VALID` out, 2 / `OPA`, `OPB` out, DW / `CIN` out, 1 / `CMD` out, CW / `MODE` out, 1 / `CE` out, 1: ALU drive.
- `RES` in, 2*DW / `COUT`, `OFLOW`, `G`, `E`, `L`, `ERR` in, 1: ALU results.
- `RSP_VALID` out, 1 / `RSP_READY` in, 1: response handshake.
- `RSP_RES` out, 2*DW: captured result.
- `RSP_FLAGS` out, 6: captured flags `{ERR,COUT,OFLOW,G,E,L}`.
- `PERF_ISSUED`, `PERF_ERR` out, 16: performance counters (see Configuration).

## Operation
- FSM states: IDLE, ISSUE_A, ISSUE_B, WAIT.
- `REQ_READY` = (state==IDLE) && FIFO not full. The request is captured into holding registers on the handshake edge.
- IDLE → ISSUE_A on accept.
- ISSUE_A drives the operation with `CE`=1:
  - Non-split: `INP_VALID`=2'b11 with both operands; next state WAIT.
  - Split: `INP_VALID`=2'b01 with OPA only; next state ISSUE_B.
- ISSUE_B drives `INP_VALID`=2'b10 with OPB. `CMD`, `MODE` and `CIN` are held identical in both cycles. Next state WAIT.
- WAIT loads a down-counter with the effective latency: Leff = LAT+1 when `MODE`=1 and `CMD` is 9 or 10 (multiply), else LAT. `INP_VALID`=00; `CE` stays 1.
- When the counter expires, `RES` and the flags are pushed into the FIFO and the FSM returns to IDLE.
- Exactly one operation is outstanding at a time. Acceptance requires a free FIFO slot, so a push never overflows.
- Outside ISSUE_A/ISSUE_B/WAIT: `INP_VALID`=00 and `CE`=0. Operand outputs hold their last value.
- FIFO: `RSP_VALID` = not empty; pop on `RSP_VALID && RSP_READY`. A push and a pop on the same edge leave the count unchanged. Pointers wrap modulo `RSP_DEPTH`.
- `ERR` is passed through unchecked. The sequencer never filters or retries commands.

## Timing
- Request accepted on edge E0.
- Non-split: operands valid during E0–E1. `RES` is sampled on edge E(1+Leff).
- Split: OPA during E0–E1, OPB during E1–E2. `RES` is sampled on edge E(2+Leff).
- `RSP_VALID` rises after the sample edge if the FIFO was empty. `REQ_READY` rises after the same edge if the FIFO is not full.
- Back-to-back throughput: one operation per 2+Leff cycles (non-split).
- Reset values: `REQ_READY`=0 during reset and 1 after deassertion; `INP_VALID`=0, `OPA`=`OPB`=0, `CIN`=0, `CMD`=0, `MODE`=0, `CE`=0, `RSP_VALID`=0, `RSP_RES`=0, `RSP_FLAGS`=0, `PERF_*`=0.
- Reset mid-operation: the in-flight command is dropped, the FIFO is flushed, and the FSM goes to IDLE immediately (asynchronous).
- `RSP_RES`/`RSP_FLAGS` must be stable while `RSP_VALID`=1 and `RSP_READY`=0.

## Configuration
- `ALU_SEQ_PERF_EN` defined:
  - `PERF_ISSUED` increments on every request accept.
  - `PERF_ERR` increments on every FIFO push with `ERR`=1.
  - Both saturate at 16'hFFFF and clear only on reset.
- `ALU_SEQ_PERF_EN` undefined: the ports remain and are tied to 0; no counter logic is generated.

## Test plan
- Reset: assert `RST`=0 mid-stream → all outputs at reset values. After release, `REQ_READY`=1 and `RSP_VALID`=0.
- Non-split ADD, LAT=1: `MODE`=1, `CMD`=0, `OPA`=8'h25, `OPB`=8'h13 → `INP_VALID`=11 for one cycle; `RSP_RES`=16'h0038 and `RSP_FLAGS`=0 captured at E2; `RSP_VALID` high after E2.
- Split CMP: `MODE`=1, `CMD`=8, `OPA`=8'h40, `OPB`=8'h40, `REQ_SPLIT`=1 → `INP_VALID` sequence 01, 10, 00. `CMD` is held across both issue cycles. Sample at E3 gives `RSP_FLAGS`=6'b000010 (E=1).
- Multiply latency: `MODE`=1, `CMD`=9, LAT=1 → `RES` is sampled at E3, not E2. `RSP_RES` matches the ALU reference-model value.
- Backpressure: `RSP_READY`=0, issue 4 requests (`RSP_DEPTH`=4) → `REQ_READY`=0 after the 4th push and a 5th request stalls. One pop re-raises `REQ_READY`. With `ALU_SEQ_PERF_EN`, `PERF_ISSUED`=5 after the 5th accept.
- Reset during WAIT → no response is pushed, `RSP_VALID`=0, and the next request completes normally.
